// File: rtl/space_invaders_pkg.sv
// Shared types and constants for the space-invaders datapath blocks.
package space_invaders_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLY      = 2'd1,
        COOLDOWN = 2'd2
    } shot_state_t;

    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_RIGHT = 8'h07;
    localparam logic [7:0] KEY_FIRE  = 8'h2C;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the asynchronous vsync strobe into the Clk domain and emits a one-Clk pulse per rising edge.
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic frame_tick
);

    logic sync1_q, sync2_q, prev_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= frame_clk;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign frame_tick = sync2_q & ~prev_q;

endmodule

// File: rtl/player_shot_ctrl.sv
// Per-frame ship movement and single-shot FSM (IDLE/FLY/COOLDOWN).
// Optional FIRE_EDGE_EN: one shot per fire-key press instead of auto-repeat while held.
module player_shot_ctrl
    import space_invaders_pkg::*;
#(
    parameter int PLAYER_X_INIT   = 320,
    parameter int PLAYER_Y        = 440,
    parameter int X_MIN           = 16,
    parameter int X_MAX           = 600,
    parameter int PLAYER_STEP     = 2,
    parameter int BULLET_STEP     = 8,
    parameter int Y_TOP           = 0,
    parameter int COOLDOWN_FRAMES = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic       hit_in,
    output logic [9:0] PlayerX,
    output logic [9:0] BulletX,
    output logic [9:0] BulletY,
    output logic       bullet_active,
    output logic       frame_tick
);

    // Saturating moves carried in 11 bits so the step can never wrap past zero or 1023.
    function automatic logic [9:0] move_left(input logic [9:0] x);
        logic [10:0] xe;
        xe = {1'b0, x};
        if (xe >= 11'(X_MIN + PLAYER_STEP)) return 10'(xe - 11'(PLAYER_STEP));
        else                                return 10'(X_MIN);
    endfunction

    function automatic logic [9:0] move_right(input logic [9:0] x);
        logic [10:0] xe;
        xe = {1'b0, x} + 11'(PLAYER_STEP);
        if (xe > 11'(X_MAX)) return 10'(X_MAX);
        else                 return xe[9:0];
    endfunction

    logic        tick;
    logic [9:0]  player_x_q, player_x_d;
    logic [9:0]  bullet_x_q, bullet_y_q;
    logic        active_q;
    logic [7:0]  cnt_q;
    shot_state_t state_q;
    logic        fire_ok, spawn, top_exit;

    frame_tick_sync u_sync (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .frame_tick(tick)
    );

    always_comb begin
        player_x_d = player_x_q;
        if (tick) begin
            case (keycode)
                KEY_LEFT:  player_x_d = move_left(player_x_q);
                KEY_RIGHT: player_x_d = move_right(player_x_q);
                default:   player_x_d = player_x_q;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) player_x_q <= 10'(PLAYER_X_INIT);
        else       player_x_q <= player_x_d;
    end

`ifdef FIRE_EDGE_EN
    logic fire_armed_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)                            fire_armed_q <= 1'b1;
        else if (spawn)                       fire_armed_q <= 1'b0;
        else if (tick && keycode != KEY_FIRE) fire_armed_q <= 1'b1;
    end

    assign fire_ok = fire_armed_q;
`else
    assign fire_ok = 1'b1;
`endif

    assign spawn    = tick && (state_q == IDLE) && (keycode == KEY_FIRE) && fire_ok;
    assign top_exit = (11'(bullet_y_q) < 11'(Y_TOP + BULLET_STEP));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            bullet_x_q <= '0;
            bullet_y_q <= '0;
            active_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (spawn) begin
                        state_q    <= FLY;
                        bullet_x_q <= player_x_q;
                        bullet_y_q <= 10'(PLAYER_Y);
                        active_q   <= 1'b1;
                    end
                end
                FLY: begin
                    // A hit and a top exit on the same tick collapse into one COOLDOWN entry.
                    if (hit_in || (tick && top_exit)) begin
                        state_q  <= COOLDOWN;
                        active_q <= 1'b0;
                        cnt_q    <= 8'(COOLDOWN_FRAMES);
                    end else if (tick) begin
                        bullet_y_q <= bullet_y_q - 10'(BULLET_STEP);
                    end
                end
                COOLDOWN: begin
                    if (tick) begin
                        if (cnt_q == 8'd0) state_q <= IDLE;
                        else               cnt_q   <= cnt_q - 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign PlayerX       = player_x_q;
    assign BulletX       = bullet_x_q;
    assign BulletY       = bullet_y_q;
    assign bullet_active = active_q;
    assign frame_tick    = tick;

endmodule

// File: tb/tb_player_shot_ctrl.sv
// Scoreboard bench for player_shot_ctrl: stimulus queues expected frame results, a monitor checks them.
module tb_player_shot_ctrl;

    typedef struct packed {
        logic [15:0] id;
        logic [9:0]  px;
        logic [9:0]  bx;
        logic [9:0]  by;
        logic        act;
        logic [9:0]  lo;
        logic [9:0]  hi;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_clk;
    logic       hit;
    logic [7:0] kc, kc_lo, kc_hi;

    logic [9:0] px, bx, by;
    logic       act, ft;
    logic [9:0] px_lo, bx_lo, by_lo, px_hi, bx_hi, by_hi;
    logic       act_lo, ft_lo, act_hi, ft_hi;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   rec_id = 0;
    bit   pend = 1'b0;
    bit   snap_req = 1'b0;

    logic [9:0] e_px, e_bx, e_by, e_lo, e_hi;
    logic       e_act;

    always #5 clk = ~clk;

    player_shot_ctrl u_dut (
        .Clk(clk), .Reset(rst), .frame_clk(frame_clk), .keycode(kc), .hit_in(hit),
        .PlayerX(px), .BulletX(bx), .BulletY(by), .bullet_active(act), .frame_tick(ft)
    );

    player_shot_ctrl #(.PLAYER_X_INIT(17)) u_lo (
        .Clk(clk), .Reset(rst), .frame_clk(frame_clk), .keycode(kc_lo), .hit_in(1'b0),
        .PlayerX(px_lo), .BulletX(bx_lo), .BulletY(by_lo), .bullet_active(act_lo), .frame_tick(ft_lo)
    );

    player_shot_ctrl #(.PLAYER_X_INIT(599)) u_hi (
        .Clk(clk), .Reset(rst), .frame_clk(frame_clk), .keycode(kc_hi), .hit_in(1'b0),
        .PlayerX(px_hi), .BulletX(bx_hi), .BulletY(by_hi), .bullet_active(act_hi), .frame_tick(ft_hi)
    );

    // Monitor: a frame result is due the cycle after frame_tick, or when the stimulus asks for a snapshot.
    always @(negedge clk) begin
        if (pend || snap_req) begin
            exp_t e;
            logic aux_ok;
            n_cmp++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_result px=%0d act=%0b by=%0d (no result was due)", px, act, by);
            end else begin
                e = q.pop_front();
                aux_ok = !act_lo && !act_hi && bx_lo == 10'd0 && by_lo == 10'd0 &&
                         bx_hi == 10'd0 && by_hi == 10'd0 && ft_lo == ft && ft_hi == ft;
                if (px !== e.px || bx !== e.bx || by !== e.by || act !== e.act ||
                    px_lo !== e.lo || px_hi !== e.hi || !aux_ok) begin
                    n_fail++;
                    $display("FAIL rec%0d got px=%0d bx=%0d by=%0d act=%0b lo=%0d hi=%0d aux_ok=%0b want px=%0d bx=%0d by=%0d act=%0b lo=%0d hi=%0d aux_ok=1",
                             e.id, px, bx, by, act, px_lo, px_hi, aux_ok,
                             e.px, e.bx, e.by, e.act, e.lo, e.hi);
                end
            end
            pend     = 1'b0;
            snap_req = 1'b0;
        end
        if (ft) pend = 1'b1;
    end

    task automatic push_exp();
        exp_t e;
        rec_id++;
        e.id = 16'(rec_id);
        e.px = e_px; e.bx = e_bx; e.by = e_by; e.act = e_act; e.lo = e_lo; e.hi = e_hi;
        q.push_back(e);
    endtask

    // One frame: raise frame_clk long enough for the synchroniser, then let it settle back.
    task automatic tick_frame();
        push_exp();
        frame_clk = 1'b1;
        repeat (3) @(posedge clk);
        #1 frame_clk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic snapshot();
        push_exp();
        snap_req = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; frame_clk = 1'b0; hit = 1'b0;
        kc = 8'h00; kc_lo = 8'h00; kc_hi = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        e_px = 10'd320; e_bx = 10'd0; e_by = 10'd0; e_act = 1'b0; e_lo = 10'd17; e_hi = 10'd599;
        snapshot();
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Right moves from 320; clamp at X_MAX from 599 and at X_MIN from 17
        kc = 8'h07; kc_hi = 8'h07; kc_lo = 8'h04;
        for (int i = 1; i <= 5; i++) begin
            if (i == 3) begin kc_lo = 8'h00; kc_hi = 8'h00; end
            e_px = 10'(320 + 2 * i);
            if (i <= 2) begin e_lo = 10'd16; e_hi = 10'd600; end
            tick_frame();
        end
        kc = 8'h04;
        for (int i = 1; i <= 5; i++) begin
            e_px = 10'(330 - 2 * i);
            tick_frame();
        end

        // Spawn at 320/440, then rise 10 frames
        kc = 8'h2C; e_act = 1'b1; e_bx = 10'd320; e_by = 10'd440;
        tick_frame();
        kc = 8'h00;
        for (int i = 1; i <= 10; i++) begin
            e_by = 10'(440 - 8 * i);
            tick_frame();
        end
        kc = 8'h07;
        for (int i = 1; i <= 2; i++) begin
            e_px = 10'(320 + 2 * i);
            e_by = 10'(360 - 8 * i);
            tick_frame();
        end

        // Fire held during flight is ignored; shot climbs to row 0 then retires
        kc = 8'h2C;
        while (e_by != 10'd0) begin
            e_by = e_by - 10'd8;
            tick_frame();
        end
        e_act = 1'b0;
        tick_frame();
        for (int i = 1; i <= 6; i++) begin
            if (i == 6) begin e_act = 1'b1; e_bx = 10'd324; e_by = 10'd440; end
            tick_frame();
        end

        // Hit during flight, then fire held through cooldown
        kc = 8'h00; e_by = 10'd432;
        tick_frame();
        hit = 1'b1;
        @(posedge clk);
        #1 hit = 1'b0;
        e_act = 1'b0;
        snapshot();
        kc = 8'h2C;
        for (int i = 1; i <= 6; i++) begin
            if (i == 6) begin e_act = 1'b1; e_by = 10'd440; end
            tick_frame();
        end

`ifdef FIRE_EDGE_EN
        // One shot per press: holding fire for 100 frames yields a single flight
        hit = 1'b1;
        @(posedge clk);
        #1 hit = 1'b0;
        e_act = 1'b0;
        snapshot();
        kc = 8'h00;
        tick_frame();
        kc = 8'h2C;
        for (int t = 1; t <= 100; t++) begin
            if (t >= 5 && t <= 60) begin
                e_act = 1'b1;
                e_by  = 10'(440 - 8 * (t - 5));
            end else if (t > 60) begin
                e_act = 1'b0;
                e_by  = 10'd0;
            end
            tick_frame();
        end
        kc = 8'h00;
        tick_frame();
        kc = 8'h2C; e_act = 1'b1; e_by = 10'd440;
        tick_frame();
`endif

        // Asynchronous reset in mid-flight, checked before the next Clk edge
        kc = 8'h07; e_px = 10'd326; e_by = 10'd432;
        tick_frame();
        kc = 8'h00;
        @(posedge clk);
        #2 rst = 1'b1;
        e_px = 10'd320; e_bx = 10'd0; e_by = 10'd0; e_act = 1'b0; e_lo = 10'd17; e_hi = 10'd599;
        push_exp();
        snap_req = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        kc = 8'h2C; e_act = 1'b1; e_bx = 10'd320; e_by = 10'd440;
        tick_frame();

        repeat (10) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL results_outstanding got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
